// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, key-length codes and GF(2^8) helpers.
// Built-in variant: encrypt only; define AES_DECRYPT_EN for the inverse datapath.
package aes_pkg;

    localparam logic [1:0] KLEN_128 = 2'd0;
    localparam logic [1:0] KLEN_192 = 2'd1;
    localparam logic [1:0] KLEN_256 = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gmul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] klen);
        case (klen)
            KLEN_128: return 4'd10;
            KLEN_192: return 4'd12;
            default:  return 4'd14;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// aes_round_comb: one combinational AES round, forward or inverse.
// The inverse path exists only when AES_DECRYPT_EN is defined.
module aes_round_comb (
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         dec,
    input  logic         last,
    output logic [127:0] nxt
);
    import aes_pkg::*;

    // Byte k sits at column k/4, row k%4; these give the source byte index
    function automatic int src_sr(input int k);
        return 4 * (((k / 4) + (k % 4)) % 4) + (k % 4);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [127:0] sr;
    logic [127:0] mc;
    logic [127:0] enc_nxt;

    // SubBytes followed by ShiftRows
    always_comb begin
        sr = '0;
        for (int k = 0; k < 16; k++)
            sr[127 - 8*k -: 8] = sbox(st[127 - 8*src_sr(k) -: 8]);
    end

    // MixColumns on the shifted state
    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++)
            mc[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
    end

    assign enc_nxt = (last ? sr : mc) ^ rk;

`ifdef AES_DECRYPT_EN
    function automatic int src_isr(input int k);
        return 4 * (((k / 4) - (k % 4) + 4) % 4) + (k % 4);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    logic [127:0] isr;
    logic [127:0] ark;
    logic [127:0] imc;

    // InvShiftRows followed by InvSubBytes
    always_comb begin
        isr = '0;
        for (int k = 0; k < 16; k++)
            isr[127 - 8*k -: 8] = inv_sbox(st[127 - 8*src_isr(k) -: 8]);
    end

    assign ark = isr ^ rk;

    // InvMixColumns after the key is added
    always_comb begin
        imc = '0;
        for (int c = 0; c < 4; c++)
            imc[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
    end

    assign nxt = dec ? (last ? ark : imc) : enc_nxt;
`else
    logic unused_dec;
    assign unused_dec = dec;
    assign nxt        = enc_nxt;
`endif

endmodule

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative one-round-per-cycle AES-128/192/256 core.
// Define AES_DECRYPT_EN to honour in_dec and build the inverse cipher.
module aes_round_engine #(
    parameter int         MAX_NR    = 14,
    parameter logic [2:0] KLEN_MASK = 3'b111,
    parameter int         RKI_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic [1:0]       in_klen,
    input  logic             in_dec,
    output logic [RKI_W-1:0] rk_idx,
    input  logic [127:0]     rk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             out_err,
    output logic             busy
);
    import aes_pkg::*;

    localparam int RW = $clog2(MAX_NR + 1);

    state_t         state;
    logic [RW-1:0]  round;
    logic [127:0]   st;
    logic [1:0]     klen_q;
    logic           dec_q;
    logic [127:0]   nxt;
    logic           last;
    logic [RW-1:0]  nr_cur;
    logic [3:0]     mask4;
    logic           klen_ok;
    logic           accept;
    logic [RKI_W-1:0] idle_idx;
    logic [RKI_W-1:0] round_idx;

    assign mask4    = {1'b0, KLEN_MASK};
    assign klen_ok  = mask4[in_klen];
    assign nr_cur   = RW'(nr_of(klen_q));
    assign last     = (round == nr_cur);
    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

`ifdef AES_DECRYPT_EN
    assign idle_idx  = in_dec ? RKI_W'(nr_of(in_klen)) : '0;
    assign round_idx = dec_q ? RKI_W'(nr_cur - round) : RKI_W'(round);
`else
    logic unused_in_dec;
    assign unused_in_dec = in_dec;
    assign dec_q         = 1'b0;
    assign idle_idx      = '0;
    assign round_idx     = RKI_W'(round);
`endif

    // Round-key index requested from the key store this cycle
    always_comb begin
        rk_idx = '0;
        unique case (state)
            IDLE:    rk_idx = idle_idx;
            ROUND:   rk_idx = round_idx;
            default: rk_idx = '0;
        endcase
    end

    aes_round_comb u_round (
        .st   (st),
        .rk   (rk),
        .dec  (dec_q),
        .last (last),
        .nxt  (nxt)
    );

    // Control FSM, round counter, state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round     <= '0;
            st        <= '0;
            klen_q    <= KLEN_128;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
`ifdef AES_DECRYPT_EN
            dec_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        klen_q <= in_klen;
`ifdef AES_DECRYPT_EN
                        dec_q  <= in_dec;
`endif
                        busy   <= 1'b1;
                        if (klen_ok) begin
                            st    <= in_data ^ rk;
                            round <= RW'(1);
                            state <= ROUND;
                        end else begin
                            out_data  <= '0;
                            out_err   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ROUND: begin
                    st    <= nxt;
                    round <= round + 1'b1;
                    if (last) begin
                        out_data  <= nxt;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        round     <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: directed FIPS-197 vectors against aes_round_engine.
// Covers AES_DECRYPT_EN builds too (decrypt vector vs. in_dec ignored).
module tb_aes_round_engine;

    logic         clk;
    logic         rst;
    logic         in_valid, in_ready, in_dec;
    logic [127:0] in_data;
    logic [1:0]   in_klen;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid, out_ready, out_err, busy;
    logic [127:0] out_data;

    logic         m_in_valid, m_in_ready, m_in_dec;
    logic [127:0] m_in_data;
    logic [1:0]   m_in_klen;
    logic [3:0]   m_rk_idx;
    logic [127:0] m_rk;
    logic         m_out_valid, m_out_ready, m_out_err, m_busy;
    logic [127:0] m_out_data;

    logic [127:0] rkey [0:15];
    logic [7:0]   sb   [0:255];
    logic [255:0] key;
    int           errors;
    int           checks;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    assign rk   = rkey[rk_idx];
    assign m_rk = rkey[m_rk_idx];

    aes_round_engine dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_klen(in_klen), .in_dec(in_dec),
        .rk_idx(rk_idx), .rk(rk),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .busy(busy)
    );

    aes_round_engine #(.KLEN_MASK(3'b101)) dut_m (
        .clk(clk), .rst(rst),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
        .in_klen(m_in_klen), .in_dec(m_in_dec),
        .rk_idx(m_rk_idx), .rk(m_rk),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
        .out_err(m_out_err), .busy(m_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from exp/log tables over generator 3
    task automatic build_sbox();
        logic [7:0] ex [0:254];
        int         lg [0:255];
        logic [7:0] x, v;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex[i] = x;
            lg[x] = i;
            x = x ^ xt(x);
        end
        for (int a = 0; a < 256; a++) begin
            v = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
            sb[a] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                      ^ {v[3:0], v[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    // Key expansion of the leading nk words of key into rkey
    task automatic load_key(input int nk);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nr;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rkey[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [127:0] d, input logic [1:0] k, input logic dec);
        in_valid = 1'b1;
        in_data  = d;
        in_klen  = k;
        in_dec   = dec;
        #1;
    endtask

    task automatic accept();
        step();
        in_valid = 1'b0;
        in_data  = '0;
        in_dec   = 1'b0;
    endtask

    // Edges after the accept edge until out_valid; 40 means timed out
    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int           lat;
        logic [127:0] held;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_klen = 2'd0; in_dec = 1'b0;
        out_ready = 1'b0;
        m_in_valid = 1'b0; m_in_data = '0; m_in_klen = 2'd0; m_in_dec = 1'b0;
        m_out_ready = 1'b0;
        for (int i = 0; i < 32; i++) key[255 - 8*i -: 8] = 8'(i);
        build_sbox();
        load_key(4);
        step();
        step();
        rst = 1'b0;
        #1;

        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_out_err", out_err, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk_i("rst_rk_idx", int'(rk_idx), 0);

        // AES-128 with 5 cycles of backpressure
        present(PT, 2'd0, 1'b0);
        accept();
        wait_out(lat);
        chk_i("lat128", lat, 10);
        chk("enc128", out_data, C128);
        chk1("err128", out_err, 1'b0);
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", out_data, held);
            chk1("bp_valid", out_valid, 1'b1);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        drain();
        chk1("post_ready", in_ready, 1'b1);
        chk1("post_valid", out_valid, 1'b0);

        // AES-192 offered the cycle after the output handshake
        load_key(6);
        present(PT, 2'd1, 1'b0);
        accept();
        chk1("acc192_busy", busy, 1'b1);
        chk1("acc192_in_ready", in_ready, 1'b0);
        wait_out(lat);
        chk_i("lat192", lat, 12);
        chk("enc192", out_data, C192);
        drain();

        // AES-256
        load_key(8);
        present(PT, 2'd2, 1'b0);
        accept();
        wait_out(lat);
        chk_i("lat256", lat, 14);
        chk("enc256", out_data, C256);
        chk1("err256", out_err, 1'b0);
        drain();

`ifdef AES_DECRYPT_EN
        present(C256, 2'd2, 1'b1);
        chk_i("dec_rk_idx0", int'(rk_idx), 14);
        accept();
        for (int j = 13; j >= 0; j--) begin
            chk_i("dec_rk_idx", int'(rk_idx), j);
            step();
        end
        chk1("dec_valid", out_valid, 1'b1);
        chk("dec256", out_data, PT);
        drain();
`else
        // in_dec must be ignored: the block is encrypted
        present(PT, 2'd2, 1'b1);
        chk_i("nodec_rk_idx0", int'(rk_idx), 0);
        accept();
        wait_out(lat);
        chk_i("nodec_lat", lat, 14);
        chk("nodec_enc", out_data, C256);
        drain();
`endif

        // klen=3: error result in the cycle after the accept cycle
        present(PT, 2'd3, 1'b0);
        accept();
        chk1("k3_valid", out_valid, 1'b1);
        chk1("k3_err", out_err, 1'b1);
        chk("k3_data", out_data, '0);
        drain();
        chk1("k3_idle", in_ready, 1'b1);

        // klen=1 disabled by mask 3'b101 on the second instance
        m_in_valid = 1'b1;
        m_in_data  = PT;
        m_in_klen  = 2'd1;
        step();
        m_in_valid = 1'b0;
        chk1("mask_valid", m_out_valid, 1'b1);
        chk1("mask_err", m_out_err, 1'b1);
        chk("mask_data", m_out_data, '0);
        m_out_ready = 1'b1;
        step();
        m_out_ready = 1'b0;
        chk1("mask_idle", m_in_ready, 1'b1);

        // Synchronous reset during round 5 of an AES-256 block
        present(PT, 2'd2, 1'b0);
        accept();
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        chk1("mid_busy", busy, 1'b0);
        chk1("mid_in_ready", in_ready, 1'b1);
        chk1("mid_valid", out_valid, 1'b0);
        rst = 1'b0;
        step();
        chk1("mid_still_idle", out_valid, 1'b0);

        load_key(4);
        present(PT, 2'd0, 1'b0);
        accept();
        wait_out(lat);
        chk_i("post_rst_lat", lat, 10);
        chk("post_rst_enc", out_data, C128);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
